// File: rtl/hsm_cmd_engine.sv
// HSM command engine: key store and key write/lock/zeroize/cipher; result 1, ROUNDS+1 or NUM_SLOTS+1 cycles after accept.
// One command in flight: cmd_ready only in IDLE, response held until rsp_ready. Key readback is enabled by HSM_KEY_READBACK_EN.
module hsm_cmd_engine #(
  parameter int SLOT_W = 3,
  parameter int ROUNDS = 4
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [SLOT_W-1:0] cmd_slot,
  input  logic [31:0]       cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_status,
  output logic              busy
);

  localparam int NUM_SLOTS = 2 ** SLOT_W;
  localparam int RND_W     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int CNT_W     = (SLOT_W > RND_W) ? SLOT_W : RND_W;
  localparam logic [31:0] DELTA = 32'h9E3779B9;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_LOCKED = 2'b01;
  localparam logic [1:0] ST_BADOP  = 2'b10;
  localparam logic [1:0] ST_EMPTY  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            key_q [NUM_SLOTS];
  logic [31:0]            key_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   vld_q, vld_d;
  logic [NUM_SLOTS-1:0]   lock_q, lock_d;
  logic [31:0]            x_q, x_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic                   dec_q, dec_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             st_q, st_d;

  logic [31:0] k_sel, enc_t, enc_x, dec_t, dec_x;

  // x_q is both the cipher working register and the held response data.
  assign k_sel = key_q[slot_q];
  assign enc_t = x_q ^ k_sel;
  assign enc_x = {enc_t[26:0], enc_t[31:27]} + DELTA;
  assign dec_t = x_q - DELTA;
  assign dec_x = {dec_t[4:0], dec_t[31:5]} ^ k_sel;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    vld_d   = vld_q;
    lock_d  = lock_q;
    x_d     = x_q;
    slot_d  = slot_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          slot_d  = cmd_slot;
          x_d     = 32'h0;
          st_d    = ST_OK;
          cnt_d   = '0;
          state_d = S_RESP;
          case (cmd_op)
            4'd0: ;
            4'd1: begin
              if (lock_q[cmd_slot]) begin
                st_d = ST_LOCKED;
              end else begin
                key_d[cmd_slot] = cmd_data;
                vld_d[cmd_slot] = 1'b1;
              end
            end
            4'd2, 4'd3: begin
              if (!vld_q[cmd_slot]) begin
                st_d = ST_EMPTY;
              end else begin
                x_d     = cmd_data;
                dec_d   = cmd_op[0];
                state_d = S_RUN;
              end
            end
            4'd4: lock_d[cmd_slot] = 1'b1;
            4'd5: state_d = S_ZERO;
`ifdef HSM_KEY_READBACK_EN
            4'd6: begin
              if (lock_q[cmd_slot])      st_d = ST_LOCKED;
              else if (!vld_q[cmd_slot]) st_d = ST_EMPTY;
              else                       x_d  = key_q[cmd_slot];
            end
`endif
            default: st_d = ST_BADOP;
          endcase
        end
      end
      S_RUN: begin
        x_d   = dec_q ? dec_x : enc_x;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ROUNDS - 1)) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_ZERO: begin
        key_d[cnt_q[SLOT_W-1:0]]  = 32'h0;
        vld_d[cnt_q[SLOT_W-1:0]]  = 1'b0;
        lock_d[cnt_q[SLOT_W-1:0]] = 1'b0;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_SLOTS - 1)) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q <= S_IDLE;
      key_q   <= '{default: '0};
      vld_q   <= '0;
      lock_q  <= '0;
      x_q     <= '0;
      slot_q  <= '0;
      dec_q   <= 1'b0;
      cnt_q   <= '0;
      st_q    <= ST_OK;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      vld_q   <= vld_d;
      lock_q  <= lock_d;
      x_q     <= x_d;
      slot_q  <= slot_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign rsp_data   = x_q;
  assign rsp_status = st_q;

endmodule

// File: tb/tb_hsm_cmd_engine.sv
// Bench for hsm_cmd_engine: directed scenarios plus random commands against a key-store reference model.
// Expected data, status and latency all come from the model below.
module tb_hsm_cmd_engine;

  localparam int SLOT_W = 3;
  localparam int ROUNDS = 4;
  localparam int NS     = 8;
  localparam logic [31:0] DELTA = 32'h9E3779B9;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [2:0]  cmd_slot = 3'd0;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_key  [NS];
  bit          m_vld  [NS];
  bit          m_lock [NS];

  always #5 clk = ~clk;

  hsm_cmd_engine #(.SLOT_W(SLOT_W), .ROUNDS(ROUNDS)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_slot(cmd_slot), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_ref(input logic [31:0] x, input logic [31:0] k);
    logic [31:0] t;
    for (int r = 0; r < ROUNDS; r++) begin
      t = x ^ k;
      x = ((t << 5) | (t >> 27)) + DELTA;
    end
    return x;
  endfunction

  function automatic logic [31:0] dec_ref(input logic [31:0] x, input logic [31:0] k);
    logic [31:0] t;
    for (int r = 0; r < ROUNDS; r++) begin
      t = x - DELTA;
      x = ((t >> 5) | (t << 27)) ^ k;
    end
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_key[i] = 32'h0; m_vld[i] = 1'b0; m_lock[i] = 1'b0;
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [2:0] s, input logic [31:0] d,
                       output logic [31:0] ed, output logic [1:0] es, output int el);
    ed = 32'h0; es = 2'b00; el = 1;
    case (op)
      4'd0: ;
      4'd1: if (m_lock[s]) es = 2'b01; else begin m_key[s] = d; m_vld[s] = 1'b1; end
      4'd2, 4'd3: begin
        if (!m_vld[s]) es = 2'b11;
        else begin
          ed = (op == 4'd2) ? enc_ref(d, m_key[s]) : dec_ref(d, m_key[s]);
          el = ROUNDS + 1;
        end
      end
      4'd4: m_lock[s] = 1'b1;
      4'd5: begin model_reset(); el = NS + 1; end
      4'd6: begin
`ifdef HSM_KEY_READBACK_EN
        if (m_lock[s])     es = 2'b01;
        else if (!m_vld[s]) es = 2'b11;
        else               ed = m_key[s];
`else
        es = 2'b10;
`endif
      end
      default: es = 2'b10;
    endcase
  endtask

  // Issue one command, check latency/data/status; hold>0 stalls rsp_ready and throws ignored commands at the DUT.
  task automatic send(input logic [3:0] op, input logic [2:0] s, input logic [31:0] d,
                      input int hold, output logic [31:0] got);
    logic [31:0] ed; logic [1:0] es; int el; int lat; int w;
    model(op, s, d, ed, es, el);
    w = 0;
    while (!cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
    chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1; cmd_op = op; cmd_slot = s; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 4'(  $urandom_range(0, 15)); cmd_data = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      chk("busy_not_ready", {30'h0, cmd_ready, busy}, 32'h1);
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("latency op%0d", op), 32'(lat), 32'(el));
    chk($sformatf("data op%0d", op), rsp_data, ed);
    chk($sformatf("status op%0d", op), {30'h0, rsp_status}, {30'h0, es});
    got = rsp_data;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 4'd1; cmd_slot = 3'd6; cmd_data = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", {30'h0, rsp_valid, cmd_ready}, 32'h2);
      chk("hold_data", rsp_data, ed);
      chk("hold_status", {30'h0, rsp_status}, {30'h0, es});
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_to_idle", {30'h0, cmd_ready, rsp_valid}, 32'h2);
  endtask

  initial begin
    logic [31:0] r, c;
    int sel;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_status", {30'h0, rsp_status}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    send(4'd1, 3'd2, 32'h0, 0, r);
    send(4'd2, 3'd2, 32'h0, 0, c);
    send(4'd3, 3'd2, c, 0, r);
    chk("t1_roundtrip", r, 32'h0);

    send(4'd1, 3'd1, 32'hDEADBEEF, 0, r);
    send(4'd2, 3'd1, 32'h12345678, 0, c);
    send(4'd3, 3'd1, c, 0, r);
    chk("t2_roundtrip", r, 32'h12345678);

    send(4'd4, 3'd3, 32'h0, 0, r);
    send(4'd1, 3'd3, 32'h1, 0, r);
    send(4'd2, 3'd3, 32'h55AA55AA, 0, r);
    send(4'd2, 3'd5, 32'h1, 0, r);
    send(4'd9, 3'd0, 32'h1, 0, r);
    send(4'd0, 3'd0, 32'hFFFFFFFF, 0, r);
    send(4'd6, 3'd1, 32'h0, 0, r);

    send(4'd2, 3'd1, 32'hA5A5A5A5, 10, r);
    send(4'd2, 3'd6, 32'h1, 0, r);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 5)       send(4'd1, 3'($urandom_range(0, 7)), $urandom, 0, r);
      else if (sel < 9)  send(4'd2, 3'($urandom_range(0, 7)), $urandom, 0, r);
      else if (sel < 12) send(4'd3, 3'($urandom_range(0, 7)), $urandom, 0, r);
      else if (sel == 12) send(4'd4, 3'($urandom_range(0, 7)), $urandom, 0, r);
      else if (sel == 13) send(4'd5, 3'($urandom_range(0, 7)), $urandom, 0, r);
      else if (sel == 14) send(4'd0, 3'($urandom_range(0, 7)), $urandom, 0, r);
      else if (sel == 15) send(4'd6, 3'($urandom_range(0, 7)), $urandom, 0, r);
      else               send(4'($urandom_range(7, 15)), 3'($urandom_range(0, 7)), $urandom, 0, r);
    end

    for (int i = 0; i < NS; i++) begin
      send(4'd1, 3'(i), $urandom, 0, r);
      send(4'd4, 3'(i), 32'h0, 0, r);
    end
    send(4'd5, 3'd0, 32'h0, 0, r);
    send(4'd1, 3'd3, 32'h0BADF00D, 0, r);
    send(4'd2, 3'd0, 32'h1, 0, r);

    send(4'd1, 3'd1, 32'h13572468, 0, r);
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_slot = 3'd1; cmd_data = 32'h1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_in_run", {31'h0, busy}, 32'h1);
    rstn = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("t6_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy}, 32'h0);
    chk("t6_rst_data", rsp_data, 32'h0);
    chk("t6_rst_status", {30'h0, rsp_status}, 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t6_no_rsp", {30'h0, rsp_valid, cmd_ready}, 32'h1);
    end
    send(4'd2, 3'd1, 32'h1, 0, r);
    send(4'd1, 3'd1, 32'hCAFEF00D, 0, r);
    send(4'd6, 3'd1, 32'h0, 0, r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
